heap_move_engine: RTL
=====================

// Module: heap_move_engine
// PURPOSE
//  Parametrised heap memory with a built-in moveLong copy engine and per-array length tracking.
//  Copies cmd_len elements from (src array, offset) to (dst array, offset) inside one single-port heap RAM.
//  Overlap-safe. Exposes a host word port for the instruction sequencer while the engine is idle.
// PARAMETERS
//  DATA_WIDTH  12  heap element width in bits
//  AREA_SIZE   16  elements per array area; power of 2
//  ARRAYS       4  number of array areas; heap depth = ARRAYS*AREA_SIZE
//  AW  (local) $clog2(ARRAYS); OW (local) $clog2(AREA_SIZE); LW (local) $clog2(AREA_SIZE+1)
// PORTS
//  clock          in   1   single clock; all state changes on posedge
//  reset          in   1   synchronous, active-high
//  cmd_valid      in   1   move request
//  cmd_ready      out  1   engine idle; request accepted on cmd_valid&&cmd_ready
//  cmd_src_array  in   AW  source array number
//  cmd_src_off    in   OW  source start offset
//  cmd_dst_array  in   AW  target array number
//  cmd_dst_off    in   OW  target start offset
//  cmd_len        in   LW  element count, 0..AREA_SIZE
//  done           out  1   one-cycle pulse at end of every accepted command
//  err            out  1   valid with done; 1 = command rejected, heap untouched
//  host_en        in   1   host word access; honoured only while cmd_ready=1
//  host_write     in   1   1 = write, 0 = read
//  host_array     in   AW  host array number
//  host_index     in   OW  host element index
//  host_wdata     in   DW  host write data
//  host_rdata     out  DW  host read data
//  host_rvalid    out  1   host_rdata valid; pulses one cycle after a read
//  size_array     in   AW  array whose length is reported
//  size_out       out  LW  combinational length of size_array
// BEHAVIOUR
//  Reset: cmd_ready=1, done=0, err=0, host_rvalid=0, host_rdata=0, all lengths=0, FSM=IDLE.
//   Heap RAM contents are not cleared. Reset mid-move aborts at once; elements already written stay.
//  Address = array*AREA_SIZE + offset. RAM is single port: one read or one write per cycle.
//  FSM: IDLE -> (accept) CHECK -> READ <-> WRITE ... -> DONE -> IDLE.
//   CHECK: err if src_off+len>AREA_SIZE or dst_off+len>AREA_SIZE (LW+1-bit sums, no wrap) -> DONE with err=1.
//   len=0: no RAM access; -> DONE with err=0.
//   READ: present source address; data registered at edge. WRITE: write registered word to target;
//   dst length = max(length, index+1). Step index; after the last element -> DONE.
//  Latency: acceptance edge = cycle 0. CHECK = cycle 1; done=1 in cycle 2L+2 for L>0 (2 for L=0 or err).
//   cmd_ready=1 again in the cycle after done.
//  Direction: ascending by default. Same array with src_off<dst_off: descending from the last element,
//   so overlapping moves copy the original data. src==dst region: performs L read/write pairs, data unchanged.
//  Host: write lands at the edge and updates that array's length as above. Read: host_rdata/host_rvalid one cycle later.
//  host_en while cmd_ready=0: ignored, no rvalid. cmd accept and host_en in the same cycle: command wins, host ignored.
//  size_out reflects a length update in the cycle after the write edge.
// CONFIGURATION
//  HEAP_MOVE_OVERLAP_EN defined: descending-copy logic as above.
//  Not defined: always ascending. Same array with src_off<dst_off<src_off+len -> err=1, no writes.
//   All other moves behave identically.
// TESTING
//  reset; host writes arr0[i]=i for i=0..9; move src 0/0 -> dst 1/0 len 3 -> done at cycle 8, err=0, arr1[0..2]=0,1,2, size(1)=3
//  move len 0 -> done at cycle 2, err=0, no RAM writes, sizes unchanged
//  move src_off=14 len=3 (AREA 16) -> done at cycle 2, err=1, heap and sizes unchanged
//  arr0=0..9; move 0/0 -> 0/2 len 5: EN -> arr0[2..6]=0,1,2,3,4; not EN -> err=1, arr0 unchanged
//  host_en read during busy move -> no host_rvalid; cmd_valid+host_en together in idle -> move only
//  reset asserted at cycle 4 of len-8 move -> next cycle cmd_ready=1, all sizes 0, done never pulses

Source files
------------

// File: rtl/heap_move_engine.sv
// Single-port heap RAM with a moveLong copy engine, per-array length table and idle-time host word port.
// Define HEAP_MOVE_OVERLAP_EN for descending copies on forward-overlapping moves (otherwise those are rejected).
module heap_move_engine #(
    parameter  int DATA_WIDTH = 12,
    parameter  int AREA_SIZE  = 16,
    parameter  int ARRAYS     = 4,
    localparam int AW         = $clog2(ARRAYS),
    localparam int OW         = $clog2(AREA_SIZE),
    localparam int LW         = $clog2(AREA_SIZE + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_src_array,
    input  logic [OW-1:0]         cmd_src_off,
    input  logic [AW-1:0]         cmd_dst_array,
    input  logic [OW-1:0]         cmd_dst_off,
    input  logic [LW-1:0]         cmd_len,
    output logic                  done,
    output logic                  err,
    input  logic                  host_en,
    input  logic                  host_write,
    input  logic [AW-1:0]         host_array,
    input  logic [OW-1:0]         host_index,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    input  logic [AW-1:0]         size_array,
    output logic [LW-1:0]         size_out
);
    localparam int HW    = AW + OW;
    localparam int DEPTH = ARRAYS * AREA_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_WRITE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         src_arr_q, src_arr_d, dst_arr_q, dst_arr_d;
    logic [OW-1:0]         src_off_q, src_off_d, dst_off_q, dst_off_d;
    logic [LW-1:0]         len_q, len_d, idx_q, idx_d;
    logic                  desc_q, desc_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  host_rvalid_q, host_rvalid_d;
    logic [LW-1:0]         len_tbl_q [ARRAYS];
    logic [LW-1:0]         len_tbl_d [ARRAYS];
    logic [DATA_WIDTH-1:0] heap_q [DEPTH];

    logic                  ram_we;
    logic [HW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, rd_word;
    logic [LW-1:0]         elem_k, wr_len;
    logic [OW-1:0]         src_pos, dst_pos;
    logic [LW:0]           src_end, dst_end;
    logic [AW-1:0]         wr_arr;
    logic                  same_arr, range_err;

    assign cmd_ready   = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = done && err_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign size_out    = len_tbl_q[size_array];

    always_comb begin
        state_d       = state_q;
        src_arr_d     = src_arr_q;
        dst_arr_d     = dst_arr_q;
        src_off_d     = src_off_q;
        dst_off_d     = dst_off_q;
        len_d         = len_q;
        idx_d         = idx_q;
        desc_d        = desc_q;
        err_d         = err_q;
        data_d        = data_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        len_tbl_d     = len_tbl_q;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;

        // Element k of the move; descending walks from the last element back to the first.
        elem_k    = desc_q ? (len_q - LW'(1) - idx_q) : idx_q;
        src_pos   = src_off_q + OW'(elem_k);
        dst_pos   = dst_off_q + OW'(elem_k);
        src_end   = (LW+1)'(src_off_q) + (LW+1)'(len_q);
        dst_end   = (LW+1)'(dst_off_q) + (LW+1)'(len_q);
        same_arr  = (src_arr_q == dst_arr_q);
        range_err = (src_end > (LW+1)'(AREA_SIZE)) || (dst_end > (LW+1)'(AREA_SIZE));

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_arr_d = cmd_src_array;
                    src_off_d = cmd_src_off;
                    dst_arr_d = cmd_dst_array;
                    dst_off_d = cmd_dst_off;
                    len_d     = cmd_len;
                    idx_d     = '0;
                    state_d   = S_CHECK;
                end else if (host_en) begin
                    ram_addr = {host_array, host_index};
                    if (host_write) begin
                        ram_we    = 1'b1;
                        ram_wdata = host_wdata;
                    end else begin
                        host_rdata_d  = rd_word;
                        host_rvalid_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
`ifdef HEAP_MOVE_OVERLAP_EN
                desc_d = same_arr && (src_off_q < dst_off_q);
                err_d  = range_err;
`else
                desc_d = 1'b0;
                err_d  = range_err || (same_arr && (src_off_q < dst_off_q) &&
                                       ((LW+1)'(dst_off_q) < src_end));
`endif
                state_d = (err_d || len_q == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                ram_addr = {src_arr_q, src_pos};
                data_d   = rd_word;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                ram_addr  = {dst_arr_q, dst_pos};
                ram_we    = 1'b1;
                ram_wdata = data_q;
                if (idx_q == len_q - LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LW'(1);
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Any write (host or engine) grows its array's length to cover the written index.
        wr_arr = ram_addr[HW-1:OW];
        wr_len = LW'(ram_addr[OW-1:0]) + LW'(1);
        if (ram_we && wr_len > len_tbl_q[wr_arr]) len_tbl_d[wr_arr] = wr_len;
    end

    assign rd_word = heap_q[ram_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            src_arr_q     <= '0;
            dst_arr_q     <= '0;
            src_off_q     <= '0;
            dst_off_q     <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            desc_q        <= 1'b0;
            err_q         <= 1'b0;
            data_q        <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            len_tbl_q     <= '{default: '0};
        end else begin
            state_q       <= state_d;
            src_arr_q     <= src_arr_d;
            dst_arr_q     <= dst_arr_d;
            src_off_q     <= src_off_d;
            dst_off_q     <= dst_off_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            desc_q        <= desc_d;
            err_q         <= err_d;
            data_q        <= data_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            len_tbl_q     <= len_tbl_d;
        end
    end

    // Heap contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (ram_we && !reset) heap_q[ram_addr] <= ram_wdata;
    end
endmodule
